// File: rtl/conv_pkg.sv
// Shared definitions for the convolution accumulation / pooling buffer:
// default widths, pool sequencer states and saturating arithmetic helpers.
package conv_pkg;

    localparam int ACC_W_DEF  = 16;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        RD0,
        RD1,
        RD2,
        RD3,
        WB,
        DONE
    } pool_state_t;

    // Clamp a wide signed value into the signed range of a w-bit word.
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                      input int unsigned       w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

    // ReLU, arithmetic right shift, then clamp into the unsigned w-bit range.
    function automatic logic signed [63:0] requant(input logic signed [63:0] v,
                                                   input int unsigned       sh,
                                                   input int unsigned       w);
        logic signed [63:0] hi;
        logic signed [63:0] s;
        hi = (64'sd1 <<< w) - 64'sd1;
        if (v < 64'sd0)
            return '0;
        s = v >>> sh;
        if (s > hi)
            return hi;
        return s;
    endfunction

endpackage

// File: rtl/conv_accum_pool_buffer_channel_bank.sv
// One output channel: accumulator RAM with read-modify-write forwarding,
// the 2x2 max / ReLU / requant datapath and the pooled result RAM.
module channel_bank
    import conv_pkg::*;
#(
    parameter int ROWS   = 28,
    parameter int COLS   = 28,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int SHIFT  = 4,
    localparam int AW    = $clog2(ROWS * COLS),
    localparam int PAW   = $clog2(ROWS * COLS / 4)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              acc_we,
    input  logic [AW-1:0]     acc_addr,
    input  logic              acc_first,
    input  logic [DATA_W-1:0] acc_value,
    input  logic [DATA_W-1:0] acc_bias,
    output logic              acc_sat,
    input  logic              pool_rd,
    input  logic [AW-1:0]     pool_addr,
    input  logic              cap_load,
    input  logic              cap_upd,
    input  logic              pool_wb,
    input  logic [PAW-1:0]    pool_waddr,
    input  logic [PAW-1:0]    rd_addr,
    output logic [DATA_W-1:0] rd_word
);

    localparam int DEPTH  = 1 << AW;
    localparam int PDEPTH = 1 << PAW;

    logic signed [ACC_W-1:0]  acc_mem [DEPTH];
    logic        [DATA_W-1:0] pool_mem [PDEPTH];

    logic signed [ACC_W-1:0]  acc_q;
    logic [AW-1:0]            ram_raddr;

    logic                     s1_valid;
    logic                     s1_first;
    logic [AW-1:0]            s1_addr;
    logic signed [DATA_W-1:0] s1_value;
    logic signed [DATA_W-1:0] s1_bias;

    logic                     fwd_valid;
    logic [AW-1:0]            fwd_addr;
    logic signed [ACC_W-1:0]  fwd_data;

    logic signed [ACC_W-1:0]  old_word;
    logic signed [ACC_W-1:0]  new_word;
    logic signed [63:0]       base64;
    logic signed [63:0]       sum64;
    logic signed [ACC_W-1:0]  mx;
    logic signed [ACC_W-1:0]  mx_final;

    assign ram_raddr = pool_rd ? pool_addr : acc_addr;
    assign rd_word   = pool_mem[rd_addr];

    // Accumulator RAM: synchronous read, write-back of the resolved RMW result.
    always_ff @(posedge clk) begin
        acc_q <= acc_mem[ram_raddr];
        if (s1_valid)
            acc_mem[s1_addr] <= new_word;
    end

    // RMW arithmetic and the running max of the pooling window.
    always_comb begin
        // The RAM read and the previous write share an edge; the forwarding
        // register holds that write so a same-address follow-up sees it.
        old_word = (fwd_valid && fwd_addr == s1_addr) ? fwd_data : acc_q;
        base64   = s1_first ? 64'(s1_bias) : 64'(old_word);
        sum64    = base64 + 64'(s1_value);
        new_word = ACC_W'(sat_signed(sum64, ACC_W));
        acc_sat  = s1_valid && (sum64 != sat_signed(sum64, ACC_W));
        mx_final = (acc_q > mx) ? acc_q : mx;
    end

    // Request pipeline, forwarding register and pooling window capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid  <= 1'b0;
            s1_first  <= 1'b0;
            s1_addr   <= '0;
            s1_value  <= '0;
            s1_bias   <= '0;
            fwd_valid <= 1'b0;
            fwd_addr  <= '0;
            fwd_data  <= '0;
            mx        <= '0;
        end else begin
            s1_valid <= acc_we;
            if (acc_we) begin
                s1_first <= acc_first;
                s1_addr  <= acc_addr;
                s1_value <= acc_value;
                s1_bias  <= acc_bias;
            end
            if (s1_valid) begin
                fwd_valid <= 1'b1;
                fwd_addr  <= s1_addr;
                fwd_data  <= new_word;
            end
            if (cap_load)
                mx <= acc_q;
            else if (cap_upd)
                mx <= mx_final;
        end
    end

    // Pooled RAM write with ReLU and requantisation of the window maximum.
    always_ff @(posedge clk) begin
        if (pool_wb)
            pool_mem[pool_waddr] <= DATA_W'(requant(64'(mx_final), SHIFT, DATA_W));
    end

endmodule

// File: rtl/conv_accum_pool_buffer.sv
// Multi-channel accumulation buffer with 2x2 max-pool sequencer and a
// one-cycle-latency pooled read port.
module conv_accum_pool_buffer
    import conv_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int ROWS   = 28,
    parameter int COLS   = 28,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int SHIFT  = 4,
    localparam int CW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int AW    = $clog2(ROWS * COLS),
    localparam int PAW   = $clog2(ROWS * COLS / 4)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              acc_valid,
    output logic              acc_ready,
    input  logic [CW-1:0]     acc_ch,
    input  logic [AW-1:0]     acc_addr,
    input  logic              acc_first,
    input  logic [DATA_W-1:0] acc_value,
    input  logic [DATA_W-1:0] acc_bias,
    input  logic              pool_start,
    output logic              pool_busy,
    output logic              pool_done,
    input  logic              rd_en,
    input  logic [CW-1:0]     rd_ch,
    input  logic [PAW-1:0]    rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              sat_flag
);

    localparam int CHN = 1 << CW;
    localparam int PR  = ROWS / 2;
    localparam int PC  = COLS / 2;
    localparam int PRW = (PR > 1) ? $clog2(PR) : 1;
    localparam int PCW = (PC > 1) ? $clog2(PC) : 1;

    pool_state_t       state;
    logic [PRW-1:0]    prow;
    logic [PCW-1:0]    pcol;
    logic              last_pos;
    logic              pool_rd;
    logic              cap_load;
    logic              cap_upd;
    logic              pool_wb;
    int unsigned       win_row;
    int unsigned       win_col;
    logic [AW-1:0]     pool_addr;
    logic [PAW-1:0]    pool_waddr;
    logic [NUM_CH-1:0] sat_vec;
    logic [DATA_W-1:0] rd_word [CHN];

    assign last_pos = (prow == PRW'(PR - 1)) && (pcol == PCW'(PC - 1));

    // Window word addressing and per-state datapath strobes.
    always_comb begin
        win_row  = 2 * 32'(prow);
        win_col  = 2 * 32'(pcol);
        pool_rd  = 1'b0;
        cap_load = 1'b0;
        cap_upd  = 1'b0;
        pool_wb  = 1'b0;
        case (state)
            RD0: pool_rd = 1'b1;
            RD1: begin
                pool_rd  = 1'b1;
                win_col  = win_col + 1;
                cap_load = 1'b1;
            end
            RD2: begin
                pool_rd = 1'b1;
                win_row = win_row + 1;
                cap_upd = 1'b1;
            end
            RD3: begin
                pool_rd = 1'b1;
                win_row = win_row + 1;
                win_col = win_col + 1;
                cap_upd = 1'b1;
            end
            WB:      pool_wb = 1'b1;
            default: ;
        endcase
        pool_addr  = AW'(win_row * COLS + win_col);
        pool_waddr = PAW'(32'(prow) * PC + 32'(pcol));
    end

    // Pool sequencer with position counters and registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            prow      <= '0;
            pcol      <= '0;
            acc_ready <= 1'b1;
            pool_busy <= 1'b0;
            pool_done <= 1'b0;
        end else begin
            pool_done <= 1'b0;
            case (state)
                IDLE: if (pool_start) begin
                    state     <= RD0;
                    prow      <= '0;
                    pcol      <= '0;
                    acc_ready <= 1'b0;
                    pool_busy <= 1'b1;
                end
                RD0: state <= RD1;
                RD1: state <= RD2;
                RD2: state <= RD3;
                RD3: state <= WB;
                WB: begin
                    if (last_pos) begin
                        state     <= DONE;
                        pool_done <= 1'b1;
                    end else begin
                        state <= RD0;
                        if (pcol == PCW'(PC - 1)) begin
                            pcol <= '0;
                            prow <= prow + 1'b1;
                        end else begin
                            pcol <= pcol + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    acc_ready <= 1'b1;
                    pool_busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky saturation flag and the registered pooled read port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_flag <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            if (state == IDLE && pool_start)
                sat_flag <= 1'b0;
            if (|sat_vec)
                sat_flag <= 1'b1;
            rd_valid <= rd_en;
            if (rd_en)
                rd_data <= rd_word[rd_ch];
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_bank
        channel_bank #(
            .ROWS   (ROWS),
            .COLS   (COLS),
            .DATA_W (DATA_W),
            .ACC_W  (ACC_W),
            .SHIFT  (SHIFT)
        ) u_bank (
            .clk        (clk),
            .rst        (rst),
            .acc_we     (acc_valid && acc_ready && acc_ch == CW'(g)),
            .acc_addr   (acc_addr),
            .acc_first  (acc_first),
            .acc_value  (acc_value),
            .acc_bias   (acc_bias),
            .acc_sat    (sat_vec[g]),
            .pool_rd    (pool_rd),
            .pool_addr  (pool_addr),
            .cap_load   (cap_load),
            .cap_upd    (cap_upd),
            .pool_wb    (pool_wb),
            .pool_waddr (pool_waddr),
            .rd_addr    (rd_addr),
            .rd_word    (rd_word[g])
        );
    end

    // Channel codes past NUM_CH read as zero.
    for (genvar g = NUM_CH; g < CHN; g++) begin : g_unused
        assign rd_word[g] = '0;
    end

endmodule

// File: tb/tb_conv_accum_pool_buffer.sv
// Randomised self-checking bench for conv_accum_pool_buffer with a
// behavioural model of the accumulator words and the pooled results.
module tb_conv_accum_pool_buffer;

    localparam int NUM_CH = 8;
    localparam int ROWS   = 28;
    localparam int COLS   = 28;
    localparam int DATA_W = 8;
    localparam int ACC_W  = 16;
    localparam int SHIFT  = 4;
    localparam int WORDS  = ROWS * COLS;
    localparam int NPOS   = WORDS / 4;
    localparam int ACC_MAX = 32767;
    localparam int ACC_MIN = -32768;

    logic       clk = 1'b0;
    logic       rst;
    logic       acc_valid;
    logic       acc_ready;
    logic [2:0] acc_ch;
    logic [9:0] acc_addr;
    logic       acc_first;
    logic [7:0] acc_value;
    logic [7:0] acc_bias;
    logic       pool_start;
    logic       pool_busy;
    logic       pool_done;
    logic       rd_en;
    logic [2:0] rd_ch;
    logic [7:0] rd_addr;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       sat_flag;

    int n_chk = 0;
    int n_bad = 0;

    int acc_m [NUM_CH][WORDS];
    bit m_sat;

    always #5 clk = ~clk;

    conv_accum_pool_buffer #(
        .NUM_CH (NUM_CH),
        .ROWS   (ROWS),
        .COLS   (COLS),
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .SHIFT  (SHIFT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .acc_valid  (acc_valid),
        .acc_ready  (acc_ready),
        .acc_ch     (acc_ch),
        .acc_addr   (acc_addr),
        .acc_first  (acc_first),
        .acc_value  (acc_value),
        .acc_bias   (acc_bias),
        .pool_start (pool_start),
        .pool_busy  (pool_busy),
        .pool_done  (pool_done),
        .rd_en      (rd_en),
        .rd_ch      (rd_ch),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .sat_flag   (sat_flag)
    );

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected pooled value: max of the 2x2 window, ReLU, divide by 2^SHIFT, clamp to 255.
    function automatic int pooled(input int ch, input int pa);
        int pr, pc, m, w;
        pr = pa / (COLS / 2);
        pc = pa % (COLS / 2);
        m  = ACC_MIN;
        for (int dr = 0; dr < 2; dr++)
            for (int dc = 0; dc < 2; dc++) begin
                w = acc_m[ch][(2 * pr + dr) * COLS + 2 * pc + dc];
                if (w > m) m = w;
            end
        if (m < 0) return 0;
        m = m / (1 << SHIFT);
        return (m > 255) ? 255 : m;
    endfunction

    task automatic do_acc(input int ch, input int addr, input bit first, input int value, input int bias);
        int r;
        @(negedge clk);
        acc_valid = 1'b1;
        acc_ch    = 3'(ch);
        acc_addr  = 10'(addr);
        acc_first = first;
        acc_value = 8'(value);
        acc_bias  = 8'(bias);
        r = first ? bias + value : acc_m[ch][addr] + value;
        if (r > ACC_MAX) begin r = ACC_MAX; m_sat = 1'b1; end
        if (r < ACC_MIN) begin r = ACC_MIN; m_sat = 1'b1; end
        acc_m[ch][addr] = r;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            acc_valid = 1'b0;
        end
    endtask

    task automatic rand_phase(input int n);
        int addr;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle(1);
            end else begin
                addr = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, WORDS - 1));
                do_acc(int'($urandom_range(0, NUM_CH - 1)), addr, ($urandom_range(0, 4) == 0),
                       int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
            end
        end
        idle(3);
    endtask

    task automatic rd_issue(input int ch, input int pa);
        @(negedge clk);
        rd_en   = 1'b1;
        rd_ch   = 3'(ch);
        rd_addr = 8'(pa);
        @(negedge clk);
        rd_en   = 1'b0;
    endtask

    task automatic sweep();
        for (int ch = 0; ch < NUM_CH; ch++)
            for (int pa = 0; pa < NPOS; pa++) begin
                rd_issue(ch, pa);
                check_eq($sformatf("pool ch%0d a%0d", ch, pa), rd_data, pooled(ch, pa));
            end
    endtask

    task automatic run_pool();
        int cnt;
        @(negedge clk);
        acc_valid  = 1'b0;
        pool_start = 1'b1;
        m_sat      = 1'b0;
        @(negedge clk);
        pool_start = 1'b0;
        cnt        = 1;
        check_eq("busy rise", pool_busy, 1);
        check_eq("ready low", acc_ready, 0);
        while (!pool_done && cnt < 3000) begin
            @(negedge clk);
            cnt++;
            pool_start = (cnt == 10);
            acc_valid  = (cnt == 20);
            if (cnt == 20) begin
                acc_ch    = 3'd0;
                acc_addr  = 10'd0;
                acc_first = 1'b1;
                acc_value = 8'd99;
                acc_bias  = 8'd99;
                check_eq("ready in pool", acc_ready, 0);
            end
            if (cnt == 5)
                check_eq("sat cleared", sat_flag, 0);
        end
        pool_start = 1'b0;
        acc_valid  = 1'b0;
        check_eq("done latency", cnt, 981);
        @(negedge clk);
        check_eq("done pulse", pool_done, 0);
        check_eq("busy fall", pool_busy, 0);
        check_eq("ready back", acc_ready, 1);
    endtask

    initial begin
        rst        = 1'b0;
        acc_valid  = 1'b0;
        acc_ch     = '0;
        acc_addr   = '0;
        acc_first  = 1'b0;
        acc_value  = '0;
        acc_bias   = '0;
        pool_start = 1'b0;
        rd_en      = 1'b0;
        rd_ch      = '0;
        rd_addr    = '0;
        m_sat      = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst acc_ready", acc_ready, 1);
        check_eq("rst pool_busy", pool_busy, 0);
        check_eq("rst pool_done", pool_done, 0);
        check_eq("rst rd_valid", rd_valid, 0);
        check_eq("rst rd_data", rd_data, 0);
        check_eq("rst sat_flag", sat_flag, 0);
        rst = 1'b1;

        // Preload every word of every channel.
        for (int ch = 0; ch < NUM_CH; ch++)
            for (int a = 0; a < WORDS; a++)
                do_acc(ch, a, 1'b1, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
        idle(3);
        check_eq("sat after preload", sat_flag, m_sat);

        rand_phase(1500);
        check_eq("sat after random", sat_flag, m_sat);

        // Directed windows.
        do_acc(0, 0, 1, 3, 5);    do_acc(0, 0, 0, -10, 0);
        do_acc(0, 1, 1, 0, 0);    do_acc(0, 28, 1, 0, 0);    do_acc(0, 29, 1, 0, 0);
        do_acc(3, 0, 1, 0, 40);   do_acc(3, 1, 1, 60, 100);
        do_acc(3, 28, 1, 0, -30); do_acc(3, 29, 1, 0, 100);
        do_acc(2, 0, 1, 0, -5);   do_acc(2, 1, 1, 0, -100);
        do_acc(2, 28, 1, 0, -1);  do_acc(2, 29, 1, 0, -128);
        do_acc(1, 0, 1, 60, 100);
        do_acc(1, 0, 0, 16, 0);   do_acc(1, 0, 0, 32, 0);
        do_acc(1, 0, 0, 48, 0);   do_acc(1, 0, 0, 64, 0);
        do_acc(1, 1, 1, 0, 0);    do_acc(1, 28, 1, 0, 0);    do_acc(1, 29, 1, 0, 0);
        do_acc(5, 58, 1, 127, 127);
        repeat (300) do_acc(5, 58, 0, 127, 0);
        do_acc(5, 59, 1, 0, 0);   do_acc(5, 86, 1, 0, 0);    do_acc(5, 87, 1, 0, 0);
        idle(3);
        check_eq("sat sticky", sat_flag, 1);
        check_eq("sat model", acc_m[5][58], ACC_MAX);

        run_pool();
        sweep();

        rd_issue(3, 0);
        check_eq("req ch3 valid", rd_valid, 1);
        check_eq("req ch3 data", rd_data, 10);
        @(negedge clk);
        check_eq("rd_valid drop", rd_valid, 0);
        check_eq("rd_data hold", rd_data, 10);
        rd_issue(0, 0);
        check_eq("acc ch0 data", rd_data, 0);
        rd_issue(2, 0);
        check_eq("relu ch2 data", rd_data, 0);
        rd_issue(1, 0);
        check_eq("fwd ch1 data", rd_data, 20);
        rd_issue(5, 15);
        check_eq("sat ch5 data", rd_data, 255);

        // Reset in the middle of a pool.
        @(negedge clk);
        pool_start = 1'b1;
        @(negedge clk);
        pool_start = 1'b0;
        repeat (98) @(negedge clk);
        check_eq("midpool busy", pool_busy, 1);
        rd_en   = 1'b1;
        rd_ch   = 3'd5;
        rd_addr = 8'd15;
        @(negedge clk);
        rd_en = 1'b0;
        check_eq("midpool rd_valid", rd_valid, 1);
        #2 rst = 1'b0;
        #1;
        check_eq("arst pool_busy", pool_busy, 0);
        check_eq("arst acc_ready", acc_ready, 1);
        check_eq("arst rd_valid", rd_valid, 0);
        check_eq("arst rd_data", rd_data, 0);
        check_eq("arst sat_flag", sat_flag, 0);
        m_sat = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        rand_phase(500);
        check_eq("sat after random2", sat_flag, m_sat);
        run_pool();
        sweep();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/conv_accum_pool_buffer.md
# conv_accum_pool_buffer

Parametrised multi-channel accumulation buffer for the convolution layer. It accumulates per-channel partial sums from the MAC datapath with a bias preload and signed saturation. On command it runs a 2x2 max-pool with ReLU and requantisation over every channel into a pooled output bank. The pooled bank is read by the next layer or the testbench through a one-cycle-latency read port. It replaces the fixed 8-channel, 8-bit result register file with halving accumulation.

## Interface
- NUM_CH, 8: output channels; one accumulator bank and one pooled bank per channel.
- ROWS, 28: feature-map rows; must be even.
- COLS, 28: feature-map columns; must be even.
- DATA_W, 8: width of the incoming value, the bias and the pooled output.
- ACC_W, 16: signed accumulator width; must be greater than DATA_W.
- SHIFT, 4: right shift applied during requantisation.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- acc_valid  in  1  accumulate request.
- acc_ready  out  1  high when accumulate requests are accepted (state IDLE).
- acc_ch  in  $clog2(NUM_CH)  target channel.
- acc_addr  in  $clog2(ROWS*COLS)  address, row-major (row*COLS+col).
- acc_first  in  1  first partial sum: the word is loaded with bias+value.
- acc_value  in  DATA_W  signed partial sum.
- acc_bias  in  DATA_W  signed bias.
- pool_start  in  1  single-cycle pool command.
- pool_busy  out  1  pool in progress.
- pool_done  out  1  one-cycle pulse at the end of the pool.
- rd_en  in  1  pooled read request.
- rd_ch  in  $clog2(NUM_CH)  channel to read.
- rd_addr  in  $clog2(ROWS*COLS/4)  pooled address (prow*(COLS/2)+pcol).
- rd_data  out  DATA_W  unsigned pooled value.
- rd_valid  out  1  rd_data is valid this cycle.
- sat_flag  out  1  sticky: an accumulate saturated since the last pool_start.

## Operation
- An accumulate happens when acc_valid && acc_ready and acc_ch < NUM_CH. Requests with acc_ch >= NUM_CH are dropped silently.
- All operands are sign-extended to ACC_W before arithmetic.
- When acc_first=1, the word becomes bias+value.
- When acc_first=0, the word becomes word+value.
- Results saturate to the signed ACC_W range, and sat_flag is set on saturation.
- Back-to-back accumulates to the same address must be correct. A write-forwarding register provides this, because the bank read is synchronous.
- FSM states and transitions:
  - IDLE: pool_start → RD0.
  - RD0 → RD1 → RD2 → RD3 → WB.
  - WB → RD0 for the next pooled position, or → DONE after the last position.
  - DONE → IDLE.
- Read order per pooled position (prow, pcol), issued on all channels in parallel:
  - RD0 issues (2prow, 2pcol).
  - RD1 issues (2prow, 2pcol+1) and captures the previous word.
  - RD2 issues (2prow+1, 2pcol) and captures.
  - RD3 issues (2prow+1, 2pcol+1) and captures.
  - WB captures the last word, then computes max of 4 (signed), ReLU (negative → 0), >>> SHIFT, saturates to unsigned DATA_W and writes the pooled bank.
- Pooled positions are visited row-major, starting at (0,0).
- pool_start clears sat_flag. A pool_start received while not in IDLE is ignored.
- The read port is usable in any state. During a pool, a read returns the current pooled bank contents, including partially updated entries. rd_ch >= NUM_CH returns 0.
- Reset does not clear memory contents. Software preloads a word with acc_first.

## Timing
- Reset values:
  - acc_ready=1
  - pool_busy=0
  - pool_done=0
  - rd_valid=0
  - rd_data=0
  - sat_flag=0
  - FSM in IDLE
- An accumulate accepted at cycle t is visible to a pool started at t+1. The read-modify-write completes at t+1 and forwarding covers it.
- pool_busy rises the cycle after pool_start and covers RD0 through DONE.
- acc_ready equals (state==IDLE).
- Pool duration is 5*(ROWS/2)*(COLS/2) cycles, plus one DONE cycle. pool_done is asserted in DONE, which is 981 cycles after pool_start at the defaults.
- Read latency is 1: rd_en at t gives rd_valid=1 and rd_data at t+1. rd_valid is low otherwise, and rd_data holds its last value.
- Reset asserted mid-pool returns the block to IDLE immediately. The pooled bank is then partially written, and its contents are undefined.

## Structure
- Shared package conv_pkg holds:
  - the ACC_W/DATA_W defaults;
  - the FSM state enum (IDLE, RD0..RD3, WB, DONE);
  - functions sat_signed(ACC_W) and requant(ACC_W→DATA_W).
- One sub-module, channel_bank, is instantiated NUM_CH times in a generate loop. It contains:
  - the accumulator RAM;
  - the pooled RAM;
  - the forwarding register;
  - the max/ReLU/requant datapath.
- The top level holds the FSM, the pooled-position counters and the read-port mux.

## Test plan
- Accumulate, then pool: ch0 addr0 with first, bias=5, value=3, then value=-10; pool. Pooled ch0 addr0 = max(-2, the other three words zeroed via first with bias 0) → 0.
- Max and requant: ch3 words (0,0),(0,1),(1,0),(1,1) = 40, 160, -30, 100; pool with SHIFT=4 → rd ch3 addr0 = 10, rd_valid exactly one cycle after rd_en.
- Saturation: repeated value=127 into one word for 300 cycles → word = 32767 and sat_flag=1; the next pool_start clears sat_flag; pooled result = 255.
- Handshake and timing:
  - acc_valid during pool is ignored (acc_ready=0) and the word is unchanged.
  - pool_done arrives 981 cycles after pool_start.
  - A second pool_start while busy has no effect.
- Forwarding: accumulates to the same address on 4 consecutive cycles, values 1,2,3,4 after first with bias=0/value=0 → word = 10.
- Reset: asserting rst mid-pool gives pool_busy=0, acc_ready=1, rd_valid=0 immediately; a new pool then completes normally.
